// File: rtl/bcd_display_pkg.sv
// rtl/bcd_display_pkg.sv - shared types and helpers for the BCD digit scanner
package bcd_display_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        GAP
    } scan_state_t;

    // Widest supported display is 8 digits; callers slice the low bits they need.
    function automatic logic [7:0] onehot(input int idx);
        return 8'b1 << idx;
    endfunction

endpackage

// File: rtl/slot_timer.sv
// rtl/slot_timer.sv - per-digit slot counter producing gap_start and slot_end pulses
module slot_timer #(
    parameter int PRESCALE = 1000,
    parameter int GUARD    = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic gap_start,
    output logic slot_end
);

    localparam int CNT_W     = $clog2(PRESCALE);
    localparam bit HAS_GUARD = (GUARD > 0);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            count <= '0;
        end else if (slot_end) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign slot_end  = run && (count == CNT_W'(PRESCALE - 1));
    assign gap_start = HAS_GUARD && run && (count == CNT_W'(PRESCALE - GUARD - 1));

endmodule

// File: rtl/bcd_digit_scanner.sv
// rtl/bcd_digit_scanner.sv - multiplexed BCD digit scanner; BCD_SCANNER_LZB_EN enables leading-zero blanking
module bcd_digit_scanner
    import bcd_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 1000,
    parameter int GUARD      = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [BCD_W*NUM_DIGITS-1:0]   load_data,
    output logic [BCD_W-1:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic                          blank
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int WORD_W = BCD_W * NUM_DIGITS;

    scan_state_t state, next_state;

    logic [WORD_W-1:0] active, active_next;
    logic [WORD_W-1:0] shadow, shadow_next;
    logic              pending, pending_next;
    logic              start, start_next;
    logic [IDX_W-1:0]  idx, idx_next;

    logic gap_start, slot_end, wrap, accept;

    logic [BCD_W-1:0]      bcd_d;
    logic [NUM_DIGITS-1:0] digit_en_d;
    logic                  blank_d;
    logic                  ready_d;
    logic [BCD_W-1:0]      digit_sel;
    logic                  lead_zero;
    logic [7:0]            oh;

    slot_timer #(
        .PRESCALE (PRESCALE),
        .GUARD    (GUARD)
    ) u_slot_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (state != IDLE),
        .gap_start (gap_start),
        .slot_end  (slot_end)
    );

    assign accept = load_valid && load_ready;
    assign wrap   = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = SCAN;
            SCAN: if (gap_start) next_state = GAP;
            GAP:  if (slot_end) next_state = SCAN;
            default: next_state = IDLE;
        endcase
    end

    // From IDLE a load goes straight to the active buffer; while scanning it waits in the shadow.
    always_comb begin
        start_next   = (state == IDLE) && accept;
        shadow_next  = ((state != IDLE) && accept) ? load_data : shadow;
        pending_next = (pending && !wrap) || ((state != IDLE) && accept);
        if (start_next) begin
            active_next = load_data;
        end else if (wrap && pending) begin
            active_next = shadow;
        end else begin
            active_next = active;
        end
        if (start || wrap) begin
            idx_next = '0;
        end else if (slot_end) begin
            idx_next = idx + 1'b1;
        end else begin
            idx_next = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            start   <= 1'b0;
            idx     <= '0;
        end else begin
            active  <= active_next;
            shadow  <= shadow_next;
            pending <= pending_next;
            start   <= start_next;
            idx     <= idx_next;
        end
    end

    always_comb begin
        digit_sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_next == IDX_W'(i)) digit_sel = active_next[i*BCD_W +: BCD_W];
        end
`ifdef BCD_SCANNER_LZB_EN
        lead_zero = (idx_next != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((IDX_W'(i) >= idx_next) && (active_next[i*BCD_W +: BCD_W] != '0)) lead_zero = 1'b0;
        end
`else
        lead_zero = 1'b0;
`endif
        oh = onehot(int'(idx_next));
    end

    always_comb begin
        bcd_d      = bcd_out;
        digit_en_d = '0;
        blank_d    = 1'b1;
        ready_d    = !pending_next && !start_next;
        case (next_state)
            SCAN: begin
                bcd_d = digit_sel;
                if (!lead_zero) begin
                    digit_en_d = oh[NUM_DIGITS-1:0];
                    blank_d    = 1'b0;
                end
            end
            GAP:     bcd_d = bcd_out;
            default: bcd_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_out    <= '0;
            digit_en   <= '0;
            blank      <= 1'b1;
            load_ready <= 1'b1;
        end else begin
            bcd_out    <= bcd_d;
            digit_en   <= digit_en_d;
            blank      <= blank_d;
            load_ready <= ready_d;
        end
    end

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// tb/tb_bcd_digit_scanner.sv - directed self-checking bench for bcd_digit_scanner (N=4, PRESCALE=8, GUARD=2)
module tb_bcd_digit_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_en;
    logic        blank;

    int checks   = 0;
    int failures = 0;

    bcd_digit_scanner #(
        .NUM_DIGITS (4),
        .PRESCALE   (8),
        .GUARD      (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .bcd_out    (bcd_out),
        .digit_en   (digit_en),
        .blank      (blank)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // c is the cycle within the frame; each slot is 6 lit cycles then 2 guard cycles.
    task automatic check_cycle(input logic [15:0] w, input logic [3:0] lit, input int c);
        int slot;
        int ph;
        slot = c / 8;
        ph   = c % 8;
        if (ph < 6 && lit[slot]) begin
            check($sformatf("en c%0d w%0h", c, w), digit_en, 32'(4'b0001 << slot));
            check($sformatf("blank c%0d w%0h", c, w), blank, 0);
            check($sformatf("bcd c%0d w%0h", c, w), bcd_out, w[slot*4 +: 4]);
        end else begin
            check($sformatf("en c%0d w%0h", c, w), digit_en, 0);
            check($sformatf("blank c%0d w%0h", c, w), blank, 1);
        end
    endtask

    task automatic run_frame(input logic [15:0] w, input logic [3:0] lit);
        for (int c = 0; c < 32; c++) begin
            check_cycle(w, lit, c);
            tick();
        end
    endtask

    task automatic load_from_idle(input logic [15:0] w);
        check("idle_ready", load_ready, 1);
        load_valid = 1'b1;
        load_data  = w;
        tick();
        load_valid = 1'b0;
        load_data  = 16'hDEAD;
        check("start_dark", digit_en, 0);
        tick();
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] mk(input int n);
        logic [15:0] r;
        for (int k = 0; k < 4; k++) r[k*4 +: 4] = 4'((n + k) % 9 + 1);
        return r;
    endfunction

    logic [15:0] cur;
    logic [15:0] nxt;
    logic [3:0]  lit_a;
    logic [3:0]  lit_b;
    int          accepts;
    int          bad;

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0;
        @(negedge clk);
        do_reset();

        check("rst_en", digit_en, 0);
        check("rst_blank", blank, 1);
        check("rst_bcd", bcd_out, 0);
        check("rst_ready", load_ready, 1);

        // Scenario 1: first frame of 0x1234, then it repeats
        load_from_idle(16'h1234);
        run_frame(16'h1234, 4'b1111);

        // Scenario 2: mid-frame load of 0x5678 waits for the wrap
        for (int c = 0; c < 32; c++) begin
            check_cycle(16'h1234, 4'b1111, c);
            if (c == 10) begin
                check("s2_ready_before", load_ready, 1);
                load_valid = 1'b1;
                load_data  = 16'h5678;
            end else begin
                load_valid = 1'b0;
                load_data  = 16'h9999;
            end
            if (c == 11) check("s2_ready_drop", load_ready, 0);
            if (c == 31) check("s2_ready_end", load_ready, 0);
            tick();
        end
        check("s2_wrap_ready", load_ready, 1);
        check("s2_wrap_bcd", bcd_out, 8);
        run_frame(16'h5678, 4'b1111);

        // Scenario 3: valid held high, new data every cycle
        cur = 16'h5678;
        nxt = 16'h5678;
        for (int f = 0; f < 3; f++) begin
            accepts = 0;
            for (int c = 0; c < 32; c++) begin
                check_cycle(cur, 4'b1111, c);
                load_valid = 1'b1;
                load_data  = mk(f * 32 + c);
                if (load_ready) begin
                    accepts++;
                    nxt = load_data;
                end
                tick();
            end
            check($sformatf("s3_accepts f%0d", f), accepts, 1);
            cur = nxt;
        end
        load_valid = 1'b0;
        run_frame(cur, 4'b1111);

        // Scenario 4: reset during digit-2 slot
        for (int c = 0; c < 18; c++) tick();
        check("s4_pre_en", digit_en, 4'b0100);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("s4_en", digit_en, 0);
        check("s4_blank", blank, 1);
        check("s4_bcd", bcd_out, 0);
        check("s4_ready", load_ready, 1);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (digit_en !== 4'b0 || blank !== 1'b1 || bcd_out !== 4'h0) bad++;
        end
        check("s4_dark_cycles", bad, 0);

        // Scenario 5: non-decimal nibbles pass through
        load_from_idle(16'hAF09);
        bad = 0;
        for (int c = 0; c < 32; c++) begin
            check_cycle(16'hAF09, 4'b1111, c);
            if ($isunknown({bcd_out, digit_en, blank, load_ready})) bad++;
            tick();
        end
        check("s5_no_x", bad, 0);

        // Scenario 6: leading-zero handling
`ifdef BCD_SCANNER_LZB_EN
        lit_a = 4'b0011;
        lit_b = 4'b0001;
`else
        lit_a = 4'b1111;
        lit_b = 4'b1111;
`endif
        do_reset();
        load_from_idle(16'h0040);
        check_cycle(16'h0040, lit_a, 0);
        load_valid = 1'b1;
        load_data  = 16'h0000;
        tick();
        load_valid = 1'b0;
        for (int c = 1; c < 32; c++) begin
            check_cycle(16'h0040, lit_a, c);
            tick();
        end
        run_frame(16'h0000, lit_b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
